// File: rtl/execute_muldiv_if.sv
// Operand/result bundle between the decode/execute latch and the execute-stage mul/div unit.
// The master is the latch side; the slave is the mul/div unit.
interface execute_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic [4:0]       opcodeIn;
  logic [4:0]       aluopIn;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic [4:0]       rdIn;
  logic             flush;
  logic             stall;
  logic             resultRdy;
  logic [WIDTH-1:0] result;
  logic [4:0]       rdOut;
  logic             exception;

  modport master (
    output opcodeIn, aluopIn, operandA, operandB, rdIn, flush,
    input  stall, resultRdy, result, rdOut, exception
  );

  modport slave (
    input  opcodeIn, aluopIn, operandA, operandB, rdIn, flush,
    output stall, resultRdy, result, rdOut, exception
  );
endinterface

// File: rtl/execute_muldiv.sv
// Multi-cycle signed multiply (radix-2 shift-add) and divide (restoring) on operand magnitudes.
// Holds the upstream latch via stall while busy; presents a one-cycle resultRdy in DONE.
module execute_muldiv #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [4:0]  OP_ALU  = 5'b00000,
  parameter logic [4:0]  ALU_MUL = 5'b00110,
  parameter logic [4:0]  ALU_DIV = 5'b00111
) (
  input logic             clock,
  input logic             reset,
  execute_muldiv_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;
  logic                 dovf_q, dovf_d;
  logic [4:0]           rd_pend_q, rd_pend_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [4:0]           rd_q, rd_d;
  logic                 exc_q, exc_d;

  logic                 is_mul, is_div, start;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, prod;
  logic                 mul_ovf;
  logic [2*WIDTH-1:0]   div_shift, div_next;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH-1:0]     quo;

  assign is_mul = (bus.opcodeIn == OP_ALU) && (bus.aluopIn == ALU_MUL);
  assign is_div = (bus.opcodeIn == OP_ALU) && (bus.aluopIn == ALU_DIV);
  assign start  = (state_q == StIdle) && (is_mul || is_div) && !bus.flush;

  assign a_mag = bus.operandA[WIDTH-1] ? -bus.operandA : bus.operandA;
  assign b_mag = bus.operandB[WIDTH-1] ? -bus.operandB : bus.operandB;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod     = neg_q ? -mul_next : mul_next;
  assign mul_ovf  = prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}};

  // Divide step: acc = {partial remainder, dividend/quotient bits}.
  assign div_shift = {acc_q[2*WIDTH-2:0], 1'b0};
  assign div_trial = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, mcand_q};
  assign div_next  = div_trial[WIDTH] ? div_shift
                                      : {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
  assign quo       = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    neg_d     = neg_q;
    dovf_d    = dovf_q;
    rd_pend_d = rd_pend_q;
    result_d  = result_q;
    rd_d      = rd_q;
    exc_d     = exc_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d     = '0;
          rd_pend_d = bus.rdIn;
          neg_d     = bus.operandA[WIDTH-1] ^ bus.operandB[WIDTH-1];
          dovf_d    = is_div && (bus.operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (bus.operandB == {WIDTH{1'b1}});
          acc_d     = {{WIDTH{1'b0}}, is_mul ? b_mag : a_mag};
          mcand_d   = is_mul ? a_mag : b_mag;
          if (is_div && (bus.operandB == '0)) begin
            state_d  = StDone;
            result_d = '0;
            rd_d     = bus.rdIn;
            exc_d    = 1'b1;
          end else begin
            state_d = is_mul ? StMul : StDiv;
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH - 1)) begin
          state_d  = StDone;
          result_d = prod[WIDTH-1:0];
          rd_d     = rd_pend_q;
          exc_d    = mul_ovf;
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH - 1)) begin
          state_d  = StDone;
          result_d = quo;
          rd_d     = rd_pend_q;
          exc_d    = dovf_q;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A flush abandons the operation without touching the visible outputs.
    if (bus.flush && (state_q != StIdle)) begin
      state_d  = StIdle;
      result_d = result_q;
      rd_d     = rd_q;
      exc_d    = exc_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      dovf_q    <= 1'b0;
      rd_pend_q <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      neg_q     <= neg_d;
      dovf_q    <= dovf_d;
      rd_pend_q <= rd_pend_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      exc_q     <= exc_d;
    end
  end

  assign bus.stall     = reset && (start || (state_q == StMul) || (state_q == StDiv));
  assign bus.resultRdy = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.rdOut     = rd_q;
  assign bus.exception = exc_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: the driver pushes model results, a monitor pops them
// whenever resultRdy is seen and checks value, destination, exception flag and completion cycle.
module tb_execute_muldiv;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [4:0] ALU_ADD = 5'b00001;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
    logic [31:0] cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  int unsigned cyc;
  int          n_checks;
  int          n_fail;
  exp_t        exp_q[$];
  logic [31:0] last_res;
  logic [4:0]  last_rd;
  logic        last_exc;

  execute_muldiv_if #(.WIDTH(32)) bus ();

  execute_muldiv #(
    .WIDTH  (32),
    .OP_ALU (OP_ALU),
    .ALU_MUL(ALU_MUL),
    .ALU_DIV(ALU_DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic exp_t model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd);
    exp_t   e;
    longint p;
    int     lo;
    e.rd  = rd;
    e.cyc = '0;
    if (mul) begin
      p     = longint'(int'(a)) * longint'(int'(b));
      lo    = int'(p);
      e.res = 32'(lo);
      e.exc = (p != longint'(lo));
    end else if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      e.res = 32'(int'(a) / int'(b));
      e.exc = 1'b0;
    end
    return e;
  endfunction

  task automatic run_op(input logic [4:0] opc, input logic [4:0] aop, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic fl,
                        input bit track);
    bit   is_mul, is_div, md, dz;
    exp_t e;
    int   hi;
    is_mul = (opc == OP_ALU) && (aop == ALU_MUL);
    is_div = (opc == OP_ALU) && (aop == ALU_DIV);
    md     = (is_mul || is_div) && !fl;
    dz     = is_div && (b == 32'd0);
    @(negedge clock);
    bus.opcodeIn = opc;
    bus.aluopIn  = aop;
    bus.operandA = a;
    bus.operandB = b;
    bus.rdIn     = rd;
    bus.flush    = fl;
    #1;
    check("start_stall", 64'(bus.stall), 64'(md));
    if (md && track) begin
      e     = model(is_mul, a, b, rd);
      e.cyc = cyc + (dz ? 32'd1 : 32'd33);
      exp_q.push_back(e);
      last_res = e.res;
      last_rd  = e.rd;
      last_exc = e.exc;
    end
    @(posedge clock);
    #1;
    bus.opcodeIn = 5'b01000;
    bus.aluopIn  = ALU_ADD;
    bus.flush    = 1'b0;
    if (!md) begin
      @(negedge clock);
      check("idle_no_rdy", 64'(bus.resultRdy), 64'd0);
      check("idle_result_held", 64'(bus.result), 64'(last_res));
      check("idle_rd_held", 64'(bus.rdOut), 64'(last_rd));
      check("idle_exc_held", 64'(bus.exception), 64'(last_exc));
    end else if (track) begin
      hi = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        if (!bus.stall) break;
        hi++;
      end
      check("stall_cycles", 64'(hi), dz ? 64'd0 : 64'd32);
    end
  endtask

  // Monitor: every resultRdy pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.resultRdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resultRdy: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 64'(bus.result), 64'(e.res));
        check("rdOut", 64'(bus.rdOut), 64'(e.rd));
        check("exception", 64'(bus.exception), 64'(e.exc));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;
    last_res = '0;
    last_rd  = '0;
    last_exc = 1'b0;
    reset    = 1'b0;
    // A mul presented during reset must not stall.
    bus.opcodeIn = OP_ALU;
    bus.aluopIn  = ALU_MUL;
    bus.operandA = 32'd3;
    bus.operandB = 32'd3;
    bus.rdIn     = 5'd1;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_rdy", 64'(bus.resultRdy), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_rd", 64'(bus.rdOut), 64'd0);
    check("rst_exc", 64'(bus.exception), 64'd0);
    bus.opcodeIn = 5'b01000;
    reset = 1'b1;

    run_op(OP_ALU, ALU_MUL, 32'd7, -32'sd3, 5'd5, 1'b0, 1'b1);
    run_op(OP_ALU, ALU_DIV, -32'sd7, 32'd2, 5'd6, 1'b0, 1'b1);
    run_op(OP_ALU, ALU_DIV, 32'd100, 32'd7, 5'd7, 1'b0, 1'b1);
    run_op(OP_ALU, ALU_DIV, 32'd5, 32'd0, 5'd8, 1'b0, 1'b1);
    run_op(OP_ALU, ALU_MUL, 32'h0001_0000, 32'h0001_0000, 5'd9, 1'b0, 1'b1);
    run_op(OP_ALU, ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0, 1'b1);

    // Non-mul/div traffic and a flushed mul in IDLE leave the unit alone.
    run_op(OP_ALU, ALU_ADD, 32'd1, 32'd2, 5'd11, 1'b0, 1'b1);
    run_op(5'b00011, ALU_MUL, 32'd4, 32'd5, 5'd12, 1'b0, 1'b1);
    run_op(OP_ALU, ALU_MUL, 32'd4, 32'd5, 5'd13, 1'b1, 1'b1);

    // Flush at C+10: IDLE at C+11, no completion, outputs untouched.
    run_op(OP_ALU, ALU_MUL, 32'd1234, 32'd99, 5'd14, 1'b0, 1'b0);
    repeat (10) @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    check("flush_stall", 64'(bus.stall), 64'd0);
    repeat (40) @(negedge clock);
    check("flush_result_held", 64'(bus.result), 64'(last_res));
    check("flush_rd_held", 64'(bus.rdOut), 64'(last_rd));
    check("flush_exc_held", 64'(bus.exception), 64'(last_exc));

    // Reset at C+5 clears everything immediately.
    run_op(OP_ALU, ALU_DIV, 32'd999, 32'd3, 5'd15, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_stall", 64'(bus.stall), 64'd0);
    check("abort_rdy", 64'(bus.resultRdy), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_rd", 64'(bus.rdOut), 64'd0);
    check("abort_exc", 64'(bus.exception), 64'd0);
    @(negedge clock);
    reset    = 1'b1;
    last_res = '0;
    last_rd  = '0;
    last_exc = 1'b0;

    // Back-to-back: the second start lands in the IDLE cycle right after DONE.
    run_op(OP_ALU, ALU_MUL, 32'd3, 32'd4, 5'd16, 1'b0, 1'b1);
    run_op(OP_ALU, ALU_DIV, 32'd12, 32'd5, 5'd17, 1'b0, 1'b1);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(3))
        0:       ra = $urandom;
        1:       ra = 32'($signed($urandom_range(200)) - 100);
        2:       ra = 32'h8000_0000;
        default: ra = 32'($urandom_range(65535));
      endcase
      case ($urandom_range(4))
        0:       rb = $urandom;
        1:       rb = 32'($signed($urandom_range(20)) - 10);
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(70000));
        default: rb = 32'd0;
      endcase
      run_op(OP_ALU, ($urandom_range(1) == 0) ? ALU_MUL : ALU_DIV, ra, rb,
             5'($urandom_range(31)), 1'b0, 1'b1);
    end

    repeat (3) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
